// File: rtl/vec_pkg.sv
// vec_pkg: shared encodings, FSM state type and width helpers for the vector decoder
package vec_pkg;

    localparam logic [6:0] OPC_VARITH = 7'b1010111;
    localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
    localparam logic [6:0] OPC_VSTORE = 7'b0100111;

    localparam logic [5:0] F6_ADD = 6'b000000;
    localparam logic [5:0] F6_SUB = 6'b000010;

    localparam logic [2:0] F3_OPIVV = 3'b000;
    localparam logic [2:0] F3_CFG   = 3'b111;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic int log2c(input int n);
        return $clog2(n);
    endfunction

    // Bits needed to index n items, never less than one.
    function automatic int bitwidth(input int n);
        return (n <= 1) ? 1 : log2c(n);
    endfunction

endpackage

// File: rtl/vec_instr_decoder_if.sv
// vec_instr_decoder_if: CVXIF-side issue channel into the vector decoder
//   instr_valid_i  source offers an instruction
//   instr_ready_o  decoder can accept
//   instr_i        32-bit instruction word
//   rs1_data_i     scalar rs1 operand (AVL or base address)
interface vec_instr_decoder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  instr_valid_i;
    logic                  instr_ready_o;
    logic [31:0]           instr_i;
    logic [DATA_WIDTH-1:0] rs1_data_i;

    modport master (output instr_valid_i, instr_i, rs1_data_i, input instr_ready_o);
    modport slave  (input instr_valid_i, instr_i, rs1_data_i, output instr_ready_o);
endinterface

// File: rtl/vec_issue_throttle.sv
// vec_issue_throttle: holds off issue while the previous vector op streams its elements
//   clk_i, rst_i  clock, asynchronous active-high reset
//   start_i       an op was accepted this cycle
//   vl_last_i     VL-1 in effect at the accepting edge
//   ready_o       high only in IDLE
module vec_issue_throttle
    import vec_pkg::*;
#(
    parameter int VLW       = 4,
    parameter int ISSUE_GAP = 2,
    parameter int CW        = 6
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [VLW-1:0] vl_last_i,
    output logic           ready_o
);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // BUSY lasts cnt+1 cycles, so loading VL+GAP-1 stalls for exactly VL+GAP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = BUSY;
                cnt_d   = CW'(vl_last_i) + CW'(ISSUE_GAP);
            end
            BUSY: if (cnt_q == '0) state_d = IDLE;
                  else             cnt_d   = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign ready_o = (state_q == IDLE);

endmodule

// File: rtl/vec_instr_decoder.sv
// vec_instr_decoder: decodes vector instructions into op strobes/fields and owns VL
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   bus                           issue channel (valid/ready, instr, rs1 data)
//   add_o/sub_o/load_o/store_o    one-cycle op strobes, cycle after transfer
//   src1_o/src2_o/dst_o           register indices
//   addr_o                        load/store address
//   vector_length_reg_o           current VL-1
//   illegal_o                     one-cycle pulse on an undecodable instruction
module vec_instr_decoder
    import vec_pkg::*;
#(
    parameter int NUM_REGS      = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int MVL           = 16,
    parameter int ADDRESS_WIDTH = 10,
    parameter int ISSUE_GAP     = 2,
    localparam int RW           = bitwidth(NUM_REGS),
    localparam int VLW          = bitwidth(MVL)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    vec_instr_decoder_if.slave       bus,
    output logic                     add_o,
    output logic                     sub_o,
    output logic                     load_o,
    output logic                     store_o,
    output logic [RW-1:0]            src1_o,
    output logic [RW-1:0]            src2_o,
    output logic [RW-1:0]            dst_o,
    output logic [ADDRESS_WIDTH-1:0] addr_o,
    output logic [VLW-1:0]           vector_length_reg_o,
    output logic                     illegal_o
);

    localparam int CW = bitwidth(MVL + ISSUE_GAP) + 1;

    logic [6:0] opc;
    logic [4:0] vd, vs1, vs2;
    logic [2:0] f3;
    logic [5:0] f6;
    logic       unused_vm;

    assign opc       = bus.instr_i[6:0];
    assign vd        = bus.instr_i[11:7];
    assign f3        = bus.instr_i[14:12];
    assign vs1       = bus.instr_i[19:15];
    assign vs2       = bus.instr_i[24:20];
    assign unused_vm = bus.instr_i[25];
    assign f6        = bus.instr_i[31:26];

    function automatic logic reg_ok(input logic [4:0] r);
        return int'(r) < NUM_REGS;
    endfunction

    logic is_add, is_sub, is_cfg, is_load, is_store, regs_ok;
    logic do_add, do_sub, do_load, do_store, do_op, bad, xfer, ready;

    assign is_add   = opc == OPC_VARITH && f3 == F3_OPIVV && f6 == F6_ADD;
    assign is_sub   = opc == OPC_VARITH && f3 == F3_OPIVV && f6 == F6_SUB;
    assign is_cfg   = opc == OPC_VARITH && f3 == F3_CFG;
    assign is_load  = opc == OPC_VLOAD;
    assign is_store = opc == OPC_VSTORE;

    // Only the register fields an op actually uses are range-checked.
    assign regs_ok = (is_add || is_sub) ? reg_ok(vd) && reg_ok(vs1) && reg_ok(vs2) :
                     is_load            ? reg_ok(vd) :
                     is_store           ? reg_ok(vd) : 1'b1;

    assign do_add   = is_add && regs_ok;
    assign do_sub   = is_sub && regs_ok;
    assign do_load  = is_load && regs_ok;
    assign do_store = is_store && regs_ok;
    assign do_op    = do_add || do_sub || do_load || do_store;
    assign bad      = !(do_op || is_cfg);
    assign xfer     = bus.instr_valid_i && ready;

    // Clamp at full operand width so large AVLs cannot alias after truncation.
    logic [DATA_WIDTH-1:0] avl;
    logic [VLW-1:0]        vl_last_new;

    assign avl         = bus.rs1_data_i;
    assign vl_last_new = (avl == '0)                ? '0 :
                         (avl >= DATA_WIDTH'(MVL))  ? VLW'(MVL - 1) :
                                                      VLW'(avl - 1'b1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            add_o               <= 1'b0;
            sub_o               <= 1'b0;
            load_o              <= 1'b0;
            store_o             <= 1'b0;
            illegal_o           <= 1'b0;
            src1_o              <= '0;
            src2_o              <= '0;
            dst_o               <= '0;
            addr_o              <= '0;
            vector_length_reg_o <= VLW'(MVL - 1);
        end else begin
            add_o     <= xfer && do_add;
            sub_o     <= xfer && do_sub;
            load_o    <= xfer && do_load;
            store_o   <= xfer && do_store;
            illegal_o <= xfer && bad;
            if (xfer && (do_add || do_sub)) begin
                src1_o <= vs1[RW-1:0];
                src2_o <= vs2[RW-1:0];
                dst_o  <= vd[RW-1:0];
            end
            if (xfer && do_load) begin
                dst_o  <= vd[RW-1:0];
                addr_o <= bus.rs1_data_i[ADDRESS_WIDTH-1:0];
            end
            if (xfer && do_store) begin
                src1_o <= vd[RW-1:0];
                addr_o <= bus.rs1_data_i[ADDRESS_WIDTH-1:0];
            end
            if (xfer && is_cfg) vector_length_reg_o <= vl_last_new;
        end
    end

    vec_issue_throttle #(
        .VLW       (VLW),
        .ISSUE_GAP (ISSUE_GAP),
        .CW        (CW)
    ) u_throttle (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (xfer && do_op),
        .vl_last_i (vector_length_reg_o),
        .ready_o   (ready)
    );

    assign bus.instr_ready_o = ready;

endmodule

// File: tb/tb_vec_instr_decoder.sv
// tb_vec_instr_decoder: directed self-checking bench for vec_instr_decoder
module tb_vec_instr_decoder;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    vec_instr_decoder_if #(.DATA_WIDTH(32)) bus ();

    logic       add_o, sub_o, load_o, store_o, illegal_o;
    logic [1:0] src1_o, src2_o, dst_o;
    logic [9:0] addr_o;
    logic [3:0] vector_length_reg_o;

    vec_instr_decoder dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .bus                 (bus),
        .add_o               (add_o),
        .sub_o               (sub_o),
        .load_o              (load_o),
        .store_o             (store_o),
        .src1_o              (src1_o),
        .src2_o              (src2_o),
        .dst_o               (dst_o),
        .addr_o              (addr_o),
        .vector_length_reg_o (vector_length_reg_o),
        .illegal_o           (illegal_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] varith(input logic [5:0] f6, input logic [4:0] vs2,
                                           input logic [4:0] vs1, input logic [2:0] f3,
                                           input logic [4:0] vd);
        return {f6, 1'b1, vs2, vs1, f3, vd, 7'b1010111};
    endfunction

    function automatic logic [31:0] vmem(input logic [4:0] r, input logic [6:0] opc);
        return {12'b0, 5'd1, 3'b000, r, opc};
    endfunction

    // {add, sub, load, store, illegal}
    function automatic logic [4:0] strobes();
        return {add_o, sub_o, load_o, store_o, illegal_o};
    endfunction

    task automatic send(input logic [31:0] w, input logic [31:0] d);
        @(negedge clk_i);
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = w;
        bus.rs1_data_i    = d;
        @(posedge clk_i);
        #1;
        bus.instr_valid_i = 1'b0;
    endtask

    // Counts cycles with ready low after the transfer; also grabs strobes one cycle later.
    task automatic busy_len(output int n, output logic [4:0] later);
        n = 0;
        later = 5'h1f;
        while (bus.instr_ready_o == 1'b0 && n < 100) begin
            n++;
            @(posedge clk_i);
            #1;
            if (n == 1) later = strobes();
        end
        if (n == 0) begin
            @(posedge clk_i);
            #1;
            later = strobes();
        end
    endtask

    task automatic op(input string tag, input logic [31:0] w, input logic [31:0] d,
                      input logic [4:0] exp_s, input int exp_busy);
        int n;
        logic [4:0] later;
        check({tag, " ready_before"}, 32'(bus.instr_ready_o), 32'd1);
        send(w, d);
        check({tag, " strobe"}, 32'(strobes()), 32'(exp_s));
        busy_len(n, later);
        check({tag, " busy_cycles"}, n, exp_busy);
        check({tag, " strobe_gone"}, 32'(later), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [4:0] later;
        bus.instr_valid_i = 1'b0;
        bus.instr_i       = '0;
        bus.rs1_data_i    = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst ready", 32'(bus.instr_ready_o), 32'd1);
        check("rst vl", 32'(vector_length_reg_o), 32'd15);
        check("rst strobes", 32'(strobes()), 32'd0);
        check("rst fields", {src1_o, src2_o, dst_o, addr_o}, 32'd0);
        rst_i = 1'b0;

        op("vadd", varith(6'b000000, 5'd3, 5'd2, 3'b000, 5'd1), 32'd0, 5'b10000, 18);
        check("vadd fields", {src1_o, src2_o, dst_o}, {26'd0, 2'd2, 2'd3, 2'd1});

        op("vsetvl5", varith(6'b0, 5'd0, 5'd0, 3'b111, 5'd0), 32'd5, 5'b00000, 0);
        check("vsetvl5 vl", 32'(vector_length_reg_o), 32'd4);
        op("vsub", varith(6'b000010, 5'd2, 5'd1, 3'b000, 5'd0), 32'd0, 5'b01000, 7);
        check("vsub fields", {src1_o, src2_o, dst_o}, {26'd0, 2'd1, 2'd2, 2'd0});

        op("vsetvl100", varith(6'b0, 5'd0, 5'd0, 3'b111, 5'd0), 32'd100, 5'b00000, 0);
        check("vsetvl100 vl", 32'(vector_length_reg_o), 32'd15);
        op("vsetvl_big", varith(6'b0, 5'd0, 5'd0, 3'b111, 5'd0), 32'h8000_0003, 5'b00000, 0);
        check("vsetvl_big vl", 32'(vector_length_reg_o), 32'd15);
        op("vsetvl0", varith(6'b0, 5'd0, 5'd0, 3'b111, 5'd0), 32'd0, 5'b00000, 0);
        check("vsetvl0 vl", 32'(vector_length_reg_o), 32'd0);

        op("vload", vmem(5'd3, 7'b0000111), 32'h12345, 5'b00100, 3);
        check("vload dst", 32'(dst_o), 32'd3);
        check("vload addr", 32'(addr_o), 32'h345);
        op("vstore", vmem(5'd2, 7'b0100111), 32'h2ab, 5'b00010, 3);
        check("vstore src1", 32'(src1_o), 32'd2);
        check("vstore addr", 32'(addr_o), 32'h2ab);

        op("ill_vd5", varith(6'b000000, 5'd1, 5'd1, 3'b000, 5'd5), 32'h3ff, 5'b00001, 0);
        check("ill_vd5 fields", {src1_o, dst_o, addr_o}, {18'd0, 2'd2, 2'd3, 10'h2ab});
        op("ill_opc", 32'h0000_00ff, 32'h0, 5'b00001, 0);
        check("ill_opc fields", {src1_o, dst_o, addr_o}, {18'd0, 2'd2, 2'd3, 10'h2ab});

        op("vsetvl16", varith(6'b0, 5'd0, 5'd0, 3'b111, 5'd0), 32'd16, 5'b00000, 0);
        check("vsetvl16 vl", 32'(vector_length_reg_o), 32'd15);
        op("vsetvl3", varith(6'b0, 5'd0, 5'd0, 3'b111, 5'd0), 32'd3, 5'b00000, 0);
        check("vsetvl3 vl", 32'(vector_length_reg_o), 32'd2);

        @(negedge clk_i);
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = varith(6'b000000, 5'd1, 5'd3, 3'b000, 5'd2);
        bus.rs1_data_i    = 32'd0;
        @(posedge clk_i);
        #1;
        check("pre_rst strobe", 32'(strobes()), 32'b10000);
        rst_i = 1'b1;
        #1;
        check("async_rst ready", 32'(bus.instr_ready_o), 32'd1);
        check("async_rst strobes", 32'(strobes()), 32'd0);
        check("async_rst vl", 32'(vector_length_reg_o), 32'd15);
        check("async_rst fields", {src1_o, src2_o, dst_o, addr_o}, 32'd0);
        @(posedge clk_i);
        #1;
        check("in_rst strobes", 32'(strobes()), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        bus.instr_valid_i = 1'b0;
        check("post_rst strobe", 32'(strobes()), 32'b10000);
        check("post_rst fields", {src1_o, src2_o, dst_o}, {26'd0, 2'd3, 2'd1, 2'd2});
        busy_len(n, later);
        check("post_rst busy_cycles", n, 18);
        check("post_rst strobe_gone", 32'(later), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
